// File: rtl/tick_arbiter.sv
// tick_arbiter: round-robin scheduler sharing one tick slot among N requesters.
// Rising edges on req latch pending bits. Pending requesters are granted one at
// a time as one-cycle one-hot ticks, and at least GAP idle cycles follow each tick.
module tick_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned GAP = 2,
    parameter int unsigned CW  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [N-1:0] pending,
    output logic [N-1:0] overrun,
    output logic         busy
);

    localparam int unsigned   PW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TICK = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    req_prev;
    logic [N-1:0]    rise;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_nxt;
    logic [PW-1:0]   sel_idx;
    logic            sel_found;
    logic            launch;
    logic [N-1:0]    gmask;
    logic [N-1:0]    pending_nxt;
    logic [N-1:0]    overrun_nxt;

    assign rise = req & ~req_prev;
    assign busy = (state != IDLE);

    // Round-robin pick: first pending index at or after rr_ptr, wrapping modulo N
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!sel_found && pending[(32'(rr_ptr) + k) % N]) begin
                sel_found = 1'b1;
                sel_idx   = PW'((32'(rr_ptr) + k) % N);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clr forces IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && (pending != '0)) state_nxt = TICK;
            end
            TICK: begin
                if (GAP == 0) state_nxt = (en && (pending != '0)) ? TICK : IDLE;
                else          state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == GAP_LAST) state_nxt = (en && (pending != '0)) ? TICK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // Output/datapath next values; a grant launches on every entry into TICK
    always_comb begin
        launch      = (state_nxt == TICK) && sel_found;
        gmask       = launch ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
        pending_nxt = clr ? '0 : ((pending & ~gmask) | rise);
        overrun_nxt = clr ? '0 : (overrun | (rise & pending & ~gmask));
        cnt_nxt     = ((state_nxt == HOLD) && (state == HOLD)) ? cnt + CW'(1) : '0;
        rr_nxt      = rr_ptr;
        if (launch) rr_nxt = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + PW'(1);
    end

    // Registered grant, pending/overrun bits, gap counter, pointer and edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            pending  <= '0;
            overrun  <= '0;
            cnt      <= '0;
            rr_ptr   <= '0;
            req_prev <= '0;
        end else begin
            grant    <= gmask;
            pending  <= pending_nxt;
            overrun  <= overrun_nxt;
            cnt      <= cnt_nxt;
            rr_ptr   <= rr_nxt;
            req_prev <= req;
        end
    end

endmodule

// File: doc/tick_arbiter.md
Name: tick_arbiter

Overview:
- Round-robin scheduler that shares a single tick slot among N requesters.
- Each requester raises a level request. The block detects its rising edge (req & ~req_prev, the same b-and-not-a gate form the team's edge gate uses) and latches a pending bit.
- Pending bits are granted one at a time as one-cycle one-hot tick pulses, with a programmable minimum gap between ticks.
- Sits between asynchronous-ish event sources and the downstream single-event consumer.

Parameters:
- N, 4, number of requesters (2..16).
- GAP, 2, idle cycles forced after every tick (0..255; 0 = back-to-back ticks allowed).
- CW, 8, width of the gap counter; must hold GAP.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  grant enable; pending capture continues when low.
- clr  in  1  synchronous clear of pending, overrun and state.
- req  in  N  level requests; one tick is generated per rising edge.
- grant  out  N  one-hot tick; high for exactly one cycle.
- pending  out  N  latched un-granted requests.
- overrun  out  N  sticky: an edge arrived while that requester was already pending.
- busy  out  1  high in TICK or HOLD.

Behaviour:
- Reset (rst_n low, asynchronous): the following all go to 0 immediately: grant, pending, overrun, busy, req_prev, rr_ptr, gap counter. State = IDLE.
- Edge detect:
  - req_prev is registered from req every cycle.
  - edge[i] = req[i] & ~req_prev[i].
  - An edge on cycle k sets pending[i] after clock edge k.
- State machine (all registered):
  - IDLE: if en && pending != 0, go to TICK. Grant the selected requester and clear its pending bit on the same edge.
  - TICK: grant is high for this cycle only.
    - If GAP == 0: go straight to TICK if en && remaining pending != 0, otherwise IDLE.
    - If GAP > 0: go to HOLD, counter = 0.
  - HOLD: grant = 0; counter increments each cycle. When counter == GAP-1:
    - if en && pending != 0, go to TICK (grant issued on that edge);
    - otherwise go to IDLE.
- Latency:
  - req rises and is sampled at edge k; pending is set after k; grant is high after edge k+1.
  - Minimum request-to-grant latency is 2 cycles from idle.
  - Grant-to-grant spacing under continuous load is exactly GAP+1 cycles.
- Arbitration:
  - Select the first pending index >= rr_ptr, wrapping modulo N.
  - After granting index i, rr_ptr = (i+1) mod N.
  - rr_ptr is unchanged while no grant is issued.
- Simultaneous events:
  - Edge on i in the same cycle pending[i] is cleared by its grant: pending[i] stays 1 (new request). overrun is not set.
  - Edge on i while pending[i] = 1 and not being granted: overrun[i] is set to 1 (sticky). pending stays 1. Only one tick is owed.
  - Multiple edges in one cycle: all set pending.
- en low:
  - No transition into TICK.
  - An in-progress TICK completes; HOLD keeps counting and then exits to IDLE.
  - Edges are still captured.
- clr (priority over everything except reset):
  - On the next edge: pending = 0, overrun = 0, state = IDLE, grant = 0, counter = 0.
  - rr_ptr and req_prev are kept, so a level held high does not retrigger.
  - An edge in the clr cycle is discarded.
- Reset mid-operation: grant drops asynchronously and all pending requests are lost.
- busy = (state != IDLE).
- Invariant: grant is one-hot or zero at all times.

Test Plan (N=4, GAP=2 unless noted):
- Reset, then req=0001 rising at edge 0 -> pending=0001 after edge 0. grant=0001 for 1 cycle after edge 1. busy high for 3 cycles (TICK + 2 HOLD). Then IDLE, pending=0000.
- req 0000 -> 1111 in one cycle -> grants 0001, 0010, 0100, 1000 in that order, spaced 3 cycles apart. rr_ptr ends at 0.
- GAP=0, req 0000 -> 0101 -> grant 0001 then 0100 on consecutive cycles, then IDLE.
- req[2] pulsed twice before it is granted (en=0 during both pulses) -> pending=0100, overrun=0100. After en=1, exactly one grant of 0100.
- req[1] rises in the same cycle grant=0010 is issued -> pending[1]=1 afterward, overrun=0000. A second grant of 0010 follows GAP+1 cycles later.
- clr asserted during HOLD with pending=1010 -> next cycle: pending=0000, overrun=0000, busy=0, no further grants. Then an rst_n pulse mid-TICK -> grant=0000 immediately, without waiting for a clock edge.
